// File: rtl/subtractor_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package subtractor_pkg;

    localparam int unsigned DIGIT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter width: enough to index every digit, never zero.
    function automatic int unsigned cnt_width(input int unsigned data_width);
        int unsigned digits;
        digits = data_width / DIGIT_WIDTH;
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/adder_4bit_ahead.sv
// 4-bit adder with carry-lookahead; used as the per-digit datapath.
module adder_4bit_ahead (
    input  logic [3:0] i_num_a,
    input  logic [3:0] i_num_b,
    input  logic       i_carry,
    output logic [3:0] o_sum_c,
    output logic       o_carry_c
);

    logic [3:0] gen;
    logic [3:0] prop;
    logic [4:0] carry;

    assign gen  = i_num_a & i_num_b;
    assign prop = i_num_a ^ i_num_b;

    assign carry[0] = i_carry;
    assign carry[1] = gen[0] | (prop[0] & carry[0]);
    assign carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & carry[0]);
    assign carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                    | (prop[2] & prop[1] & prop[0] & carry[0]);
    assign carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                    | (prop[3] & prop[2] & prop[1] & gen[0])
                    | (prop[3] & prop[2] & prop[1] & prop[0] & carry[0]);

    assign o_sum_c   = prop ^ carry[3:0];
    assign o_carry_c = carry[4];

endmodule

// File: rtl/subtractor_xbit_digit_serial.sv
// Digit-serial a - b - brw, one 4-bit digit per clock through a single lookahead adder.
// Optional SUBTRACTOR_XBIT_OVF_EN adds the signed overflow output o_ovf.
module subtractor_xbit_digit_serial
    import subtractor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    input  logic                  i_brw,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_brw
`ifdef SUBTRACTOR_XBIT_OVF_EN
    ,
    output logic                  o_ovf
`endif
);

    localparam int unsigned NUM_DIGITS = DATA_WIDTH / DIGIT_WIDTH;
    localparam int unsigned CNT_W      = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

    if ((DATA_WIDTH < DIGIT_WIDTH) || ((DATA_WIDTH % DIGIT_WIDTH) != 0)) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 4 and at least 4");
    end

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   nb_q;
    logic [DATA_WIDTH-1:0]   res_q;
    logic                    carry_q;
    logic                    valid_q;
    logic                    ready_q;
    logic                    brw_q;
    logic [DIGIT_WIDTH-1:0]  a_dig;
    logic [DIGIT_WIDTH-1:0]  nb_dig;
    logic [DIGIT_WIDTH-1:0]  sum;
    logic                    carry_out;
`ifdef SUBTRACTOR_XBIT_OVF_EN
    logic                    ovf_q;
`endif

    // Select the operand digits addressed by the counter.
    always_comb begin
        a_dig  = '0;
        nb_dig = '0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (cnt == CNT_W'(k)) begin
                a_dig  = a_q[k*DIGIT_WIDTH +: DIGIT_WIDTH];
                nb_dig = nb_q[k*DIGIT_WIDTH +: DIGIT_WIDTH];
            end
        end
    end

    adder_4bit_ahead u_digit_adder (
        .i_num_a   (a_dig),
        .i_num_b   (nb_dig),
        .i_carry   (carry_q),
        .o_sum_c   (sum),
        .o_carry_c (carry_out)
    );

    // Control FSM and datapath registers; B is stored inverted so the adder subtracts.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            a_q     <= '0;
            nb_q    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            brw_q   <= 1'b0;
`ifdef SUBTRACTOR_XBIT_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_q     <= i_num_a;
                        nb_q    <= ~i_num_b;
                        carry_q <= ~i_brw;
                        cnt     <= '0;
                        ready_q <= 1'b0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
                        if (cnt == CNT_W'(k)) begin
                            res_q[k*DIGIT_WIDTH +: DIGIT_WIDTH] <= sum;
                        end
                    end
                    carry_q <= carry_out;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST_DIGIT) begin
                        valid_q <= 1'b1;
                        brw_q   <= ~carry_out;
`ifdef SUBTRACTOR_XBIT_OVF_EN
                        // a and b signs differ (nb holds ~b) and result sign departs from a.
                        ovf_q   <= (a_q[DATA_WIDTH-1] == nb_q[DATA_WIDTH-1])
                                 && (sum[DIGIT_WIDTH-1] != a_q[DATA_WIDTH-1]);
`endif
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_res   = res_q;
    assign o_brw   = brw_q;
`ifdef SUBTRACTOR_XBIT_OVF_EN
    assign o_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_subtractor_xbit_digit_serial.sv
// Directed bench for subtractor_xbit_digit_serial at widths 4, 8, 16 and 32.
module tb_subtractor_xbit_digit_serial;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] opa [4];
    logic [31:0] opb [4];
    logic [3:0]  tvalid;
    logic [3:0]  tbrw;
    logic [3:0]  tready;

    logic [31:0] ores [4];
    logic [3:0]  ovalid;
    logic [3:0]  ordy;
    logic [3:0]  obrw;
`ifdef SUBTRACTOR_XBIT_OVF_EN
    logic [3:0]  oovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] last_res;
    logic        last_brw;
    logic        last_ovf;
    int          last_lat;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned WG = 4 << g;
        logic [WG-1:0] res_w;
        subtractor_xbit_digit_serial #(.DATA_WIDTH(WG)) dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_valid (tvalid[g]),
            .o_ready (ordy[g]),
            .i_num_a (opa[g][WG-1:0]),
            .i_num_b (opb[g][WG-1:0]),
            .i_brw   (tbrw[g]),
            .o_valid (ovalid[g]),
            .i_ready (tready[g]),
            .o_res   (res_w),
            .o_brw   (obrw[g])
`ifdef SUBTRACTOR_XBIT_OVF_EN
            ,
            .o_ovf   (oovf[g])
`endif
        );
        assign ores[g] = 32'(res_w);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Drive one operation on DUT idx, wait (bounded) for o_valid, record, then hand off.
    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b, input logic brw);
        int cnt;
        @(negedge clk);
        opa[idx]    = a;
        opb[idx]    = b;
        tbrw[idx]   = brw;
        tvalid[idx] = 1'b1;
        tready[idx] = 1'b0;
        @(posedge clk);
        #1;
        tvalid[idx] = 1'b0;
        opa[idx]    = 32'hA5A5_5A5A;
        opb[idx]    = 32'h0F0F_F0F0;
        tbrw[idx]   = ~brw;
        cnt = 0;
        while (!ovalid[idx] && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        last_lat = cnt;
        last_res = ores[idx];
        last_brw = obrw[idx];
`ifdef SUBTRACTOR_XBIT_OVF_EN
        last_ovf = oovf[idx];
`else
        last_ovf = 1'b0;
`endif
        tready[idx] = 1'b1;
        @(posedge clk);
        #1;
        tready[idx] = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (ovalid[1] !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", ovalid[1]); end
        n_cmp++;
        if (ores[1] !== 32'h0) begin n_bad++; $display("FAIL reset_res: got %h expected 0", ores[1]); end
        n_cmp++;
        if (obrw[1] !== 1'b0) begin n_bad++; $display("FAIL reset_brw: got %b expected 0", obrw[1]); end
        n_cmp++;
        if (ordy[1] !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", ordy[1]); end
    endtask

    task automatic test_basic();
        logic [31:0] va [4] = '{32'h5A, 32'h00, 32'h80, 32'h10};
        logic [31:0] vb [4] = '{32'h3C, 32'h01, 32'h01, 32'h0F};
        logic [3:0]  vi     = 4'b1000;
        logic [31:0] er [4] = '{32'h1E, 32'hFF, 32'h7F, 32'h00};
        logic [3:0]  eb     = 4'b0010;
        logic [3:0]  eo     = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            run_op(1, va[i], vb[i], vi[i]);
            n_cmp++;
            if (last_lat !== 2) begin n_bad++; $display("FAIL basic_lat[%0d]: got %0d expected 2", i, last_lat); end
            n_cmp++;
            if (last_res !== er[i]) begin n_bad++; $display("FAIL basic_res[%0d]: got %h expected %h", i, last_res, er[i]); end
            n_cmp++;
            if (last_brw !== eb[i]) begin n_bad++; $display("FAIL basic_brw[%0d]: got %b expected %b", i, last_brw, eb[i]); end
`ifdef SUBTRACTOR_XBIT_OVF_EN
            n_cmp++;
            if (last_ovf !== eo[i]) begin n_bad++; $display("FAIL basic_ovf[%0d]: got %b expected %b", i, last_ovf, eo[i]); end
`else
            if (eo[i] === 1'bx) $display("unexpected");
`endif
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        opa[1] = 32'h5A; opb[1] = 32'h3C; tbrw[1] = 1'b0; tvalid[1] = 1'b1; tready[1] = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (ordy[1] !== 1'b0) begin n_bad++; $display("FAIL bp_busy_ready: got %b expected 0", ordy[1]); end
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            opa[1] = 32'h10 + 32'(i); opb[1] = 32'h03; tvalid[1] = 1'b1; tready[1] = 1'b0;
            n_cmp++;
            if (ovalid[1] !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, ovalid[1]); end
            n_cmp++;
            if (ores[1] !== 32'h1E) begin n_bad++; $display("FAIL bp_res[%0d]: got %h expected 1e", i, ores[1]); end
            n_cmp++;
            if (ordy[1] !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, ordy[1]); end
        end
        @(negedge clk);
        opa[1] = 32'h44; opb[1] = 32'h04; tvalid[1] = 1'b1; tready[1] = 1'b1;
        @(posedge clk);
        #1;
        tready[1] = 1'b0;
        n_cmp++;
        if (ovalid[1] !== 1'b0) begin n_bad++; $display("FAIL bp_handoff_valid: got %b expected 0", ovalid[1]); end
        n_cmp++;
        if (ordy[1] !== 1'b1) begin n_bad++; $display("FAIL bp_handoff_ready: got %b expected 1", ordy[1]); end
        @(posedge clk);
        #1;
        tvalid[1] = 1'b0;
        n_cmp++;
        if (ordy[1] !== 1'b0) begin n_bad++; $display("FAIL bp_next_accept: got %b expected 0", ordy[1]); end
        @(posedge clk);
        @(posedge clk);
        #1;
        n_cmp++;
        if (ovalid[1] !== 1'b1) begin n_bad++; $display("FAIL bp_next_valid: got %b expected 1", ovalid[1]); end
        n_cmp++;
        if (ores[1] !== 32'h40) begin n_bad++; $display("FAIL bp_next_res: got %h expected 40", ores[1]); end
        tready[1] = 1'b1;
        @(posedge clk);
        #1;
        tready[1] = 1'b0;
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        opa[1] = 32'hFF; opb[1] = 32'h00; tbrw[1] = 1'b0; tvalid[1] = 1'b1;
        @(posedge clk);
        #1;
        tvalid[1] = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ovalid[1] !== 1'b0) begin n_bad++; $display("FAIL abort_valid[%0d]: got %b expected 0", i, ovalid[1]); end
        end
        n_cmp++;
        if (ordy[1] !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b expected 1", ordy[1]); end
        run_op(1, 32'h33, 32'h11, 1'b0);
        n_cmp++;
        if (last_lat !== 2) begin n_bad++; $display("FAIL abort_lat: got %0d expected 2", last_lat); end
        n_cmp++;
        if (last_res !== 32'h22) begin n_bad++; $display("FAIL abort_res: got %h expected 22", last_res); end
    endtask

    task automatic test_wide16();
        run_op(2, 32'h1234, 32'h4321, 1'b0);
        n_cmp++;
        if (last_lat !== 4) begin n_bad++; $display("FAIL w16_lat: got %0d expected 4", last_lat); end
        n_cmp++;
        if (last_res !== 32'hCF13) begin n_bad++; $display("FAIL w16_res: got %h expected cf13", last_res); end
        n_cmp++;
        if (last_brw !== 1'b1) begin n_bad++; $display("FAIL w16_brw: got %b expected 1", last_brw); end
    endtask

    // Fixed vectors across every width, expected values from a - b - brw.
    task automatic test_sweep();
        logic [31:0] va [6] = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h8000_0007};
        logic [31:0] vb [6] = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h9ABC_DEF0, 32'h0BAD_F00D, 32'h7FFF_FFF9};
        logic [5:0]  vi     = 6'b010101;
        for (int w = 0; w < 4; w++) begin
            int unsigned wd;
            longint      mask;
            wd   = 4 << w;
            mask = (64'd1 << wd) - 64'd1;
            for (int i = 0; i < 6; i++) begin
                longint      am, bm, d;
                logic [31:0] eres;
                logic        ebrw;
                am   = longint'(va[i]) & mask;
                bm   = longint'(vb[i]) & mask;
                d    = am - bm - longint'(vi[i]);
                ebrw = (d < 0);
                eres = 32'(d & mask);
                run_op(w, 32'(am), 32'(bm), vi[i]);
                n_cmp++;
                if (last_lat !== int'(wd / 4)) begin n_bad++; $display("FAIL sweep_lat w%0d[%0d]: got %0d expected %0d", wd, i, last_lat, wd / 4); end
                n_cmp++;
                if (last_res !== eres) begin n_bad++; $display("FAIL sweep_res w%0d[%0d]: got %h expected %h", wd, i, last_res, eres); end
                n_cmp++;
                if (last_brw !== ebrw) begin n_bad++; $display("FAIL sweep_brw w%0d[%0d]: got %b expected %b", wd, i, last_brw, ebrw); end
`ifdef SUBTRACTOR_XBIT_OVF_EN
                begin
                    logic eovf;
                    eovf = (am[wd-1] != bm[wd-1]) && (eres[wd-1] != am[wd-1]);
                    n_cmp++;
                    if (last_ovf !== eovf) begin n_bad++; $display("FAIL sweep_ovf w%0d[%0d]: got %b expected %b", wd, i, last_ovf, eovf); end
                end
`endif
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        tvalid = '0;
        tbrw   = '0;
        tready = '0;
        do_reset();
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_abort();
        test_wide16();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
